// File: rtl/fp_pkg.sv
// Shared single-precision constants and the accumulator state encoding.
package fp_pkg;

  localparam int FP_W = 32;
  localparam logic [FP_W-1:0] FP_SIGN_MASK = 32'h8000_0000;
  localparam logic [FP_W-1:0] FP_POS_ZERO  = 32'h0000_0000;
  localparam logic [FP_W-1:0] FP_QNAN      = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } acc_state_t;

endpackage

// File: rtl/fp_adder.sv
// Combinational IEEE-754 binary32 adder: round-to-nearest-even, gradual underflow,
// infinities and a canonical quiet NaN.
module fp_adder
  import fp_pkg::*;
(
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  output logic [FP_W-1:0] s
);

  logic        a_nan, b_nan, a_inf, b_inf, swap, eff_sub, sticky, round_up;
  logic [31:0] x, y;
  logic [9:0]  ex, ey, d, sh, e_res;
  logic [23:0] mx, my;
  logic [26:0] xe, ye, ye_sh, norm;
  logic [27:0] sum;
  logic [4:0]  lz;
  logic [24:0] mr;

  always_comb begin
    a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);

    // x always carries the larger magnitude, so the subtraction below never goes negative
    swap = b[30:0] > a[30:0];
    x    = swap ? b : a;
    y    = swap ? a : b;
    ex   = (x[30:23] == 8'd0) ? 10'd1 : {2'b00, x[30:23]};
    ey   = (y[30:23] == 8'd0) ? 10'd1 : {2'b00, y[30:23]};
    mx   = {x[30:23] != 8'd0, x[22:0]};
    my   = {y[30:23] != 8'd0, y[22:0]};
    d    = ex - ey;

    xe     = {mx, 3'b000};
    ye     = {my, 3'b000};
    sticky = 1'b0;
    for (int i = 0; i < 27; i++) begin
      if (i < int'(d)) sticky = sticky | ye[i];
    end
    ye_sh    = (d >= 10'd27) ? 27'd0 : (ye >> d);
    ye_sh[0] = ye_sh[0] | sticky;

    eff_sub = x[31] ^ y[31];
    sum     = eff_sub ? ({1'b0, xe} - {1'b0, ye_sh}) : ({1'b0, xe} + {1'b0, ye_sh});

    lz = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (sum[i]) lz = 5'(26 - i);
    end

    // Left shift is capped so the exponent never drops below 1 (denormal results)
    sh = 10'd0;
    if (sum[27]) begin
      norm  = {sum[27:2], sum[1] | sum[0]};
      e_res = ex + 10'd1;
    end else begin
      sh    = ({5'd0, lz} > (ex - 10'd1)) ? (ex - 10'd1) : {5'd0, lz};
      norm  = sum[26:0] << sh;
      e_res = ex - sh;
    end

    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    mr       = {1'b0, norm[26:3]} + {24'd0, round_up};
    if (mr[24]) begin
      mr    = mr >> 1;
      e_res = e_res + 10'd1;
    end

    if (a_nan || b_nan || (a_inf && b_inf && (a[31] ^ b[31]))) begin
      s = FP_QNAN;
    end else if (a_inf || b_inf) begin
      s = {x[31], 8'hFF, 23'd0};
    end else if (sum == 28'd0) begin
      s = {x[31] & y[31], 31'd0};
    end else if (e_res >= 10'd255) begin
      s = {x[31], 8'hFF, 23'd0};
    end else begin
      s = {x[31], (mr[23] ? e_res[7:0] : 8'd0), mr[22:0]};
    end
  end

endmodule

// File: rtl/fp_accumulator.sv
// Streaming reduction front-end: folds a run of binary32 operands into one sum
// through a single combinational fp_adder in the accumulator feedback loop.
module fp_accumulator
  import fp_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             sub,
  input  logic             in_valid,
  input  logic [FP_W-1:0]  in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [FP_W-1:0]  out_sum,
  input  logic             out_ready,
  output logic             busy
);

  acc_state_t       state_reg, state_next;
  logic [FP_W-1:0]  acc_reg;
  logic [FP_W-1:0]  adder_b;
  logic [FP_W-1:0]  adder_s;
  logic [LEN_W-1:0] count_reg;
  logic             sub_reg;
  logic             accept;

  assign accept  = in_valid && in_ready;
  assign adder_b = in_data ^ (sub_reg ? FP_SIGN_MASK : FP_POS_ZERO);
  assign out_sum = acc_reg;

  fp_adder u_adder (
    .a (acc_reg),
    .b (adder_b),
    .s (adder_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = (len == '0) ? DONE : ACC;
      ACC:     if (accept && (count_reg == LEN_W'(1))) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ready/valid are pure state decodes: no combinational in_valid -> in_ready path
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_reg)
      IDLE:    busy      = 1'b0;
      ACC:     in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: busy      = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg   <= FP_POS_ZERO;
      count_reg <= '0;
      sub_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (start) begin
          acc_reg   <= FP_POS_ZERO;
          count_reg <= len;
          sub_reg   <= sub;
        end
        ACC: if (accept) begin
          acc_reg   <= adder_s;
          count_reg <= count_reg - LEN_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_accumulator.sv
// Scoreboard bench for fp_accumulator: directed runs plus randomized fixed-point runs.
module tb_fp_accumulator;
  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst_n, start, sub, in_valid, out_ready;
  logic [LEN_W-1:0] len;
  logic [31:0]      in_data;
  logic             in_ready, out_valid, busy;
  logic [31:0]      out_sum;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] sb_q[$];
  logic [31:0] op_q[$];

  always #5 clk = ~clk;

  fp_accumulator #(.LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .sub(sub),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_sum(out_sum), .out_ready(out_ready), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  // Value v in units of 1/16 -> binary32 bits; magnitudes stay below 2^24 so every sum is exact
  function automatic logic [31:0] to_fp(input int v);
    int m, p;
    logic [31:0] r;
    if (v == 0) return 32'h0000_0000;
    m = (v < 0) ? -v : v;
    p = 0;
    for (int i = 0; i < 24; i++) if (m >= (1 << i)) p = i;
    r[31]    = (v < 0);
    r[30:23] = 8'(p - 4 + 127);
    r[22:0]  = 23'((m << (23 - p)) & 32'h007F_FFFF);
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_result: got %08h, expected no result", out_sum);
      end else begin
        logic [31:0] exp;
        exp = sb_q.pop_front();
        $display("result %08h expected %08h", out_sum, exp);
        check("out_sum", out_sum, exp);
      end
    end
  end

  // Called at posedge+1 in IDLE; returns at posedge+1 back in IDLE
  task automatic run(input int n, input bit s, input logic [31:0] exp, input int gmin,
                     input int gmax, input int stall, input bit hs_start);
    int  wait_n;
    bit  rdy;
    sb_q.push_back(exp);
    start = 1'b1;
    len   = LEN_W'(n);
    sub   = s;
    @(posedge clk); #1;
    start = 1'b0;
    len   = LEN_W'($urandom);
    sub   = 1'($urandom);
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b0;
      repeat ($urandom_range(gmax, gmin)) begin
        start = 1'($urandom);
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = op_q[k];
      start    = 1'($urandom);
      wait_n   = 0;
      do begin
        @(negedge clk); rdy = in_ready;
        @(posedge clk); #1;
        wait_n++;
      end while (!rdy && wait_n < 20);
      if (!rdy) check("in_ready_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      in_data  = $urandom;
    end
    start = 1'b0;
    for (int c = 0; c <= stall; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      @(negedge clk);
      check("done_out_valid", 32'(out_valid), 32'd1);
      check("done_out_sum", out_sum, exp);
      check("done_busy", 32'(busy), 32'd1);
      check("done_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    start     = hs_start;
    wait_n    = 0;
    do begin
      @(negedge clk); rdy = out_valid;
      @(posedge clk); #1;
      wait_n++;
    end while (!rdy && wait_n < 20);
    out_ready = 1'b0;
    start     = 1'b0;
    if (!rdy) check("out_valid_timeout", 32'(out_valid), 32'd1);
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, total, v;
    bit s;
    rst_n = 1'b0; start = 1'b0; len = '0; sub = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_out_sum", out_sum, 32'h0000_0000);
    rst_n = 1'b1;
    @(posedge clk); #1;

    op_q = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000};
    run(3, 1'b0, 32'h40C0_0000, 0, 0, 0, 1'b0);
    op_q = '{32'h3F80_0000, 32'h4000_0000};
    run(2, 1'b1, 32'hC040_0000, 0, 0, 0, 1'b0);
    run(0, 1'b0, 32'h0000_0000, 0, 0, 0, 1'b0);
    op_q = '{32'h3F80_0000, 32'h4000_0000};
    run(2, 1'b0, 32'h4040_0000, 2, 2, 3, 1'b1);
    op_q = '{32'h7F80_0000, 32'h3F80_0000};
    run(2, 1'b0, 32'h7F80_0000, 0, 0, 0, 1'b0);
    op_q = '{32'h3F80_0000, 32'h3380_0000};
    run(2, 1'b0, 32'h3F80_0000, 0, 1, 0, 1'b0);
    op_q = '{32'h3F80_0001, 32'h3380_0000};
    run(2, 1'b0, 32'h3F80_0002, 0, 1, 0, 1'b0);
    op_q = '{32'h0000_0001, 32'h0000_0001};
    run(2, 1'b0, 32'h0000_0002, 0, 0, 1, 1'b0);

    // Abort mid-run: reset must clear outputs without waiting for a clock edge
    start = 1'b1; len = LEN_W'(3); sub = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; in_data = 32'h3F80_0000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("abort_in_ready", 32'(in_ready), 32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_out_sum", out_sum, 32'h0000_0000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    op_q = '{32'h4000_0000};
    run(1, 1'b0, 32'h4000_0000, 0, 0, 0, 1'b0);

    for (int r = 0; r < 25; r++) begin
      n     = $urandom_range(6, 0);
      s     = 1'($urandom_range(1, 0));
      total = 0;
      op_q.delete();
      for (int k = 0; k < n; k++) begin
        v = int'($urandom_range(8192, 0)) - 4096;
        op_q.push_back(to_fp(v));
        total += s ? -v : v;
      end
      run(n, s, to_fp(total), 0, 2, $urandom_range(3, 0), 1'($urandom_range(1, 0)));
    end

    repeat (2) @(posedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
